phrase_reader: RTL and testbench

PHRASE_READER -- requirements
Module: phrase_reader

---
 rtl/phrase_reader_if.sv | 24 ++
 rtl/phrase_reader.sv | 89 ++++++++
 tb/tb_phrase_reader.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/phrase_reader_if.sv
// Phrase reader bus: start/base request, RAM read port, character stream and run status.
// The slave modport is the reader's view; the master modport is the requester/RAM/sink side.
interface phrase_reader_if;
    logic       start;
    logic [7:0] base_addr;
    logic [7:0] ram_address;
    logic [7:0] ram_q;
    logic [7:0] char_data;
    logic       char_valid;
    logic       char_ready;
    logic       busy;
    logic       done;
    logic [8:0] count;

    modport master (
        output start, base_addr, ram_q, char_ready,
        input  ram_address, char_data, char_valid, busy, done, count
    );

    modport slave (
        input  start, base_addr, ram_q, char_ready,
        output ram_address, char_data, char_valid, busy, done, count
    );
endinterface

// File: rtl/phrase_reader.sv
// Streams a TERM-terminated phrase (at most MAX_LEN chars) from a byte RAM; optional PHRASE_READER_UPPER_EN uppercases a..z.
// Latency: first char valid two edges after start is sampled; each accepted char costs at least 2 cycles.
// Backpressure: char_valid/char_data hold in PRESENT until char_ready; nothing is read from RAM meanwhile.
module phrase_reader #(
    parameter int         MAX_LEN = 65,
    parameter logic [7:0] TERM    = 8'h00
) (
    input  logic           clock,
    input  logic           reset,
    phrase_reader_if.slave bus
);

    typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;

    state_t     state, state_nxt;
    logic [7:0] ptr;
    logic [8:0] index;
    logic [7:0] char_reg;
    logic [7:0] fetch_char;
    logic       at_limit;
    logic       is_term;

    assign at_limit = (index == 9'(MAX_LEN));
    assign is_term  = (bus.ram_q == TERM);

`ifdef PHRASE_READER_UPPER_EN
    // Terminator detection above uses the raw byte; only the presented char is folded.
    assign fetch_char = (bus.ram_q >= 8'h61 && bus.ram_q <= 8'h7A) ? (bus.ram_q - 8'h20) : bus.ram_q;
`else
    assign fetch_char = bus.ram_q;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = FETCH;
            FETCH:   state_nxt = (at_limit || is_term) ? DONE : PRESENT;
            PRESENT: if (bus.char_ready) state_nxt = FETCH;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // index doubles as the accepted-character count: both clear on start and step on acceptance.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr      <= 8'h00;
            index    <= 9'd0;
            char_reg <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        ptr   <= bus.base_addr;
                        index <= 9'd0;
                    end
                end
                FETCH: begin
                    if (!at_limit && !is_term) begin
                        char_reg <= fetch_char;
                    end
                end
                PRESENT: begin
                    if (bus.char_ready) begin
                        ptr   <= ptr + 8'd1;
                        index <= index + 9'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ram_address = ptr;
    assign bus.char_data   = char_reg;
    assign bus.char_valid  = (state == PRESENT);
    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
    assign bus.count       = index;

endmodule

// File: tb/tb_phrase_reader.sv
// Scoreboarded bench for phrase_reader: a phrase-walking model queues expected chars/counts, a negedge monitor checks them.
module tb_phrase_reader;

    localparam int         MAX_LEN = 65;
    localparam logic [7:0] TERM    = 8'h00;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   ready_mode = 0;   // 0 low, 1 high, 2 random

    logic [7:0] ram [0:255];
    exp_t       exp_q[$];
    int         exp_cnt_q[$];
    bit         prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;

    phrase_reader_if bus ();

    phrase_reader #(.MAX_LEN(MAX_LEN), .TERM(TERM)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    assign bus.ram_q = ram[bus.ram_address];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] conv(input logic [7:0] b);
`ifdef PHRASE_READER_UPPER_EN
        if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
`endif
        return b;
    endfunction

    // Reference: walk the RAM from base, stop on TERM or after MAX_LEN chars.
    task automatic expect_run(input logic [7:0] base, output int n);
        logic [7:0] p;
        exp_t e;
        p = base;
        n = 0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (ram[p] == TERM) break;
            e.addr = p;
            e.data = conv(ram[p]);
            exp_q.push_back(e);
            p = p + 8'd1;
            n++;
        end
        exp_cnt_q.push_back(n);
    endtask

    // Sink ready driver.
    initial begin
        bus.char_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                1:       bus.char_ready = 1'b1;
                2:       bus.char_ready = 1'($urandom_range(0, 1));
                default: bus.char_ready = 1'b0;
            endcase
        end
    end

    // Monitor / scoreboard.
    always @(negedge clock) begin
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("valid_held", 32'(bus.char_valid), 32'd1);
                check("data_stable", 32'(bus.char_data), 32'(prev_data));
            end
            if (bus.char_valid) begin
                check("valid_expected", 32'(exp_q.size() != 0), 32'd1);
            end
            if (bus.char_valid && bus.char_ready) begin
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("char_data", 32'(bus.char_data), 32'(e.data));
                    check("ram_address", 32'(bus.ram_address), 32'(e.addr));
                end
                prev_hold = 1'b0;
            end else begin
                prev_hold = bus.char_valid;
                prev_data = bus.char_data;
            end
            if (bus.done) begin
                check("done_expected", 32'(exp_cnt_q.size() != 0), 32'd1);
                if (exp_cnt_q.size() != 0) begin
                    check("done_count", 32'(bus.count), 32'(exp_cnt_q.pop_front()));
                    check("chars_left_at_done", 32'(exp_q.size()), 32'd0);
                end
            end
        end
    end

    task automatic start_run(input logic [7:0] base, output int n);
        expect_run(base, n);
        @(posedge clock); #1;
        bus.base_addr = base;
        bus.start     = 1'b1;
        @(posedge clock); #1;
        bus.start     = 1'b0;
        bus.base_addr = 8'($urandom);
    endtask

    task automatic wait_valid(input string name);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            @(negedge clock);
            if (bus.char_valid) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic wait_done(input int n);
        bit seen;
        seen = bus.done;
        for (int c = 0; c < 4000 && !seen; c++) begin
            @(negedge clock);
            if (bus.done) seen = 1'b1;
        end
        check("done_seen", 32'(seen), 32'd1);
        @(negedge clock);
        check("busy_after_done", 32'(bus.busy), 32'd0);
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("count_held", 32'(bus.count), 32'(n));
    endtask

    task automatic run_phrase(input logic [7:0] base, input int rmode, input bit spurious);
        int n;
        ready_mode = rmode;
        start_run(base, n);
        @(negedge clock);
        check("busy_rise", 32'(bus.busy), 32'd1);
        @(negedge clock);
        check("first_valid_latency", 32'(bus.char_valid), 32'(n > 0));
        if (spurious && n > 0) begin
            bus.start     = 1'b1;
            bus.base_addr = 8'($urandom);
            @(posedge clock); #1;
            bus.start = 1'b0;
        end
        wait_done(n);
        repeat (2) @(posedge clock);
    endtask

    task automatic load_hola(input bit lower);
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        ram[0] = lower ? 8'h68 : 8'h48;
        ram[1] = lower ? 8'h6F : 8'h4F;
        ram[2] = lower ? 8'h6C : 8'h4C;
        ram[3] = lower ? 8'h61 : 8'h41;
        ram[4] = 8'h00;
    endtask

    initial begin
        int n;
        bus.start     = 1'b0;
        bus.base_addr = 8'h00;
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;

        @(posedge clock); #1;
        check("rst_char_valid", 32'(bus.char_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_char_data", 32'(bus.char_data), 32'd0);
        check("rst_ram_address", 32'(bus.ram_address), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        load_hola(1'b0);
        run_phrase(8'h00, 1, 1'b0);

        // Stall on first char for 5 cycles.
        ready_mode = 0;
        start_run(8'h00, n);
        wait_valid("stall_valid");
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check("stall_valid_hold", 32'(bus.char_valid), 32'd1);
            check("stall_data_48", 32'(bus.char_data), 32'h48);
        end
        ready_mode = 1;
        wait_done(n);

        // Address wrap.
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        ram[8'hFE] = 8'h41;
        ram[8'hFF] = 8'h42;
        ram[8'h00] = 8'h43;
        ram[8'h01] = 8'h00;
        run_phrase(8'hFE, 2, 1'b1);

        // No terminator: MAX_LEN limit; then an empty phrase.
        for (int i = 0; i < 256; i++) ram[i] = 8'h2A;
        run_phrase(8'h10, 1, 1'b0);
        ram[0] = 8'h00;
        run_phrase(8'h00, 1, 1'b0);

        // Lowercase phrase: converted only when the uppercase build is selected.
        load_hola(1'b1);
        run_phrase(8'h00, 2, 1'b0);

        // Reset during PRESENT of the 2nd char.
        load_hola(1'b0);
        ready_mode = 0;
        start_run(8'h00, n);
        wait_valid("abort_first_valid");
        ready_mode = 1;
        @(posedge clock); #2;
        ready_mode = 0;
        @(posedge clock);
        wait_valid("abort_second_valid");
        check("abort_second_char", 32'(bus.char_data), 32'h4F);
        #2;
        reset = 1'b1;
        exp_q.delete();
        exp_cnt_q.delete();
        #1;
        check("abort_char_valid", 32'(bus.char_valid), 32'd0);
        check("abort_char_data", 32'(bus.char_data), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_count", 32'(bus.count), 32'd0);
        check("abort_ram_address", 32'(bus.ram_address), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        run_phrase(8'h00, 1, 1'b0);

        // Randomized phrases.
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 256; i++) begin
                ram[i] = ($urandom_range(0, 19) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            end
            run_phrase(8'($urandom), ($urandom_range(0, 2) == 0) ? 1 : 2, 1'($urandom_range(0, 1)));
        end

        check("final_char_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_count_queue_empty", 32'(exp_cnt_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
